dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port. Accepts one request at a time over a valid/ready handshake and returns the result over a second valid/ready handshake after a configurable latency.
- Owns word-addressed data storage and handles byte/halfword/word lanes, sign/zero extension, and misalignment and out-of-range errors.
- Replaces the ideal zero-latency data memory so the core's stall logic can be exercised.

---
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering one load/store at a time with byte/half/word lanes and error checks.
// Response appears LATENCY cycles after accept; held until resp_ready, and req_ready stays low until the response handshake.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IW-1:0] idx;
    logic [4:0]    sh_amt;
    logic [31:0]   old_word, shifted_rd, shifted_wd, bit_mask, merged, load_dat;
    logic [3:0]    lane_mask;
    logic          accept, req_err, mem_we;

    assign idx        = req_addr[IW+1:2];
    assign sh_amt     = {req_addr[1:0], 3'b000};
    assign old_word   = mem_q[idx];
    assign shifted_rd = old_word >> sh_amt;
    assign shifted_wd = req_wdata << sh_amt;

    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr >= ADDR_LIM);

    always_comb begin
        lane_mask = 4'b1111;
        load_dat  = shifted_rd;
        case (req_size)
            2'b00: begin
                lane_mask = 4'b0001 << req_addr[1:0];
                load_dat  = req_unsigned ? {24'h0, shifted_rd[7:0]}
                                         : {{24{shifted_rd[7]}}, shifted_rd[7:0]};
            end
            2'b01: begin
                lane_mask = 4'b0011 << {req_addr[1], 1'b0};
                load_dat  = req_unsigned ? {16'h0, shifted_rd[15:0]}
                                         : {{16{shifted_rd[15]}}, shifted_rd[15:0]};
            end
            default: ;
        endcase
    end

    assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    assign merged   = (old_word & ~bit_mask) | (shifted_wd & bit_mask);

    assign accept = (state_q == S_IDLE) && req_valid;
    assign mem_we = accept && req_we && !req_err && rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d   = req_err;
                    rdata_d = (req_err || req_we) ? 32'h0 : load_dat;
                    if (LATENCY <= 1) begin
                        state_d = S_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; the write enable already excludes reset edges.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/errors/backpressure/reset,
// LATENCY=1 instance for single-cycle latency and blocked back-to-back issue.
module tb_dmem_responder;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [1:0]  b_req_size;
    logic        b_resp_valid, b_resp_ready, b_resp_err;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat);
        int k = 1;
        while (!resp_valid && k < 20) begin
            step();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(exp_lat));
        chk({tag, " ready_low"}, 32'(req_ready), 32'd0);
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, " valid_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(tag, we, addr, size, uns, wdata);
        wait_resp(tag, 2);
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
        finish_resp(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_size = '0;
        b_req_unsigned = 1'b0; b_req_wdata = '0; b_resp_ready = 1'b0;

        repeat (2) step();
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        step();

        txn("sw10", 1'b1, 32'h10, SZ_W, 1'b0, 32'hABCDEF11, 32'h0, 1'b0);
        txn("lw10", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hABCDEF11, 1'b0);
        txn("sb11", 1'b1, 32'h11, SZ_B, 1'b0, 32'h00000080, 32'h0, 1'b0);
        txn("lw10_b", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hABCD8011, 1'b0);
        txn("lb11", 1'b0, 32'h11, SZ_B, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        txn("lbu11", 1'b0, 32'h11, SZ_B, 1'b1, 32'h0, 32'h00000080, 1'b0);
        txn("sh12", 1'b1, 32'h12, SZ_H, 1'b0, 32'h00001234, 32'h0, 1'b0);
        txn("lw10_h", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h12348011, 1'b0);
        txn("lh12", 1'b0, 32'h12, SZ_H, 1'b0, 32'h0, 32'h00001234, 1'b0);
        txn("lh10", 1'b0, 32'h10, SZ_H, 1'b0, 32'h0, 32'hFFFF8011, 1'b0);
        txn("lhu10", 1'b0, 32'h10, SZ_H, 1'b1, 32'h0, 32'h00008011, 1'b0);
        txn("lwu10", 1'b0, 32'h10, SZ_W, 1'b1, 32'h0, 32'h12348011, 1'b0);

        txn("lw12_mis", 1'b0, 32'h12, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("sw14", 1'b1, 32'h14, SZ_W, 1'b0, 32'h55667788, 32'h0, 1'b0);
        txn("sw16_mis", 1'b1, 32'h16, SZ_W, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("sh15_mis", 1'b1, 32'h15, SZ_H, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("lw14_kept", 1'b0, 32'h14, SZ_W, 1'b0, 32'h0, 32'h55667788, 1'b0);
        txn("lw100_oor", 1'b0, 32'h100, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("size11", 1'b0, 32'h10, SZ_X, 1'b0, 32'h0, 32'h0, 1'b1);
        txn("swfc", 1'b1, 32'hFC, SZ_W, 1'b0, 32'h89ABCDEF, 32'h0, 1'b0);
        txn("lbff", 1'b0, 32'hFF, SZ_B, 1'b0, 32'h0, 32'hFFFFFF89, 1'b0);
        txn("sb101_oor", 1'b1, 32'h101, SZ_B, 1'b0, 32'h0, 32'h0, 1'b1);

        // Backpressure: response must stay put while resp_ready is low.
        issue("bp", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        wait_resp("bp", 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp hold_valid", 32'(resp_valid), 32'd1);
            chk("bp hold_rdata", resp_rdata, 32'h12348011);
            chk("bp hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        finish_resp("bp");

        // Reset while waiting on a load: transaction dropped.
        issue("mid", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        rst_n = 1'b0;
        step();
        chk("mid rst_valid", 32'(resp_valid), 32'd0);
        chk("mid rst_ready", 32'(req_ready), 32'd1);
        chk("mid rst_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid no_resp", 32'(resp_valid), 32'd0);
        end

        // Store committed at accept survives an immediate reset.
        issue("swrst", 1'b1, 32'h20, SZ_W, 1'b0, 32'hCAFEBABE);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("swrst idle", 32'(req_ready), 32'd1);
        txn("lw20", 1'b0, 32'h20, SZ_W, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0);

        // LATENCY=1 instance.
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8;
        b_req_size = SZ_W; b_req_wdata = 32'h0BADF00D;
        chk("l1 ready", 32'(b_req_ready), 32'd1);
        step();
        b_req_we = 1'b0;
        chk("l1 sw_valid", 32'(b_resp_valid), 32'd1);
        chk("l1 sw_err", 32'(b_resp_err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("l1 b2b_blocked", 32'(b_req_ready), 32'd0);
            step();
        end
        b_resp_ready = 1'b1;
        step();
        b_resp_ready = 1'b0;
        chk("l1 hs_valid", 32'(b_resp_valid), 32'd0);
        chk("l1 hs_ready", 32'(b_req_ready), 32'd1);
        step();
        b_req_valid = 1'b0;
        chk("l1 lw_valid", 32'(b_resp_valid), 32'd1);
        chk("l1 lw_rdata", b_resp_rdata, 32'h0BADF00D);
        chk("l1 lw_ready_low", 32'(b_req_ready), 32'd0);
        b_resp_ready = 1'b1;
        step();
        b_resp_ready = 1'b0;
        chk("l1 lw_done", 32'(b_resp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
